// File: rtl/mano_io_port_if.sv
// CPU-side strobes, flags and serial pins of the Mano programmed-I/O port.
// master drives strobes and the rx pin; slave is the device that owns tx and the flags.
interface mano_io_port_if;
  logic       outr_load;
  logic [7:0] outr_in;
  logic       inpr_read;
  logic       err_clr;
  logic       rx;
  logic       tx;
  logic [7:0] inpr_out;
  logic       FGI;
  logic       FGO;
  logic       irq;
  logic       rx_overrun;
  logic       frame_err;

  modport master (
    output outr_load, outr_in, inpr_read, err_clr, rx,
    input  tx, inpr_out, FGI, FGO, irq, rx_overrun, frame_err
  );

  modport slave (
    input  outr_load, outr_in, inpr_read, err_clr, rx,
    output tx, inpr_out, FGI, FGO, irq, rx_overrun, frame_err
  );
endinterface

// File: rtl/mano_io_port.sv
// Mano I/O device: OUTR bytes to UART tx (FGO), UART rx frames to INPR (FGI); IO_PARITY_EN adds even parity.
// Latency: FGO returns 1+10*CLKS_PER_BIT cycles after outr_load (1+11*CLKS_PER_BIT with parity); FGI sets at mid-stop.
// Backpressure: outr_load is dropped while FGO=0; a good frame arriving while FGI=1 is dropped and sets rx_overrun.
module mano_io_port #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mano_io_port_if.slave bus_io
);

  localparam logic [15:0] CPB  = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF = CPB >> 1;

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_q;
  logic        fgo_q;
`ifdef IO_PARITY_EN
  logic        tx_par_q;
`endif
  logic        tx_bit_end_d;

  assign tx_bit_end_d = (tx_cnt_q == CPB - 16'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      fgo_q      <= 1'b1;
`ifdef IO_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          if (bus_io.outr_load && fgo_q) begin
            tx_shift_q <= bus_io.outr_in;
`ifdef IO_PARITY_EN
            tx_par_q   <= ^bus_io.outr_in;
`endif
            fgo_q      <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= T_START;
          end
        end
        T_START: begin
          // Line drops one cycle after the load; the start bit then lasts CPB full cycles.
          if (tx_cnt_q == 16'd0) tx_q <= 1'b0;
          if (tx_cnt_q == CPB) begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= T_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        T_DATA: begin
          if (tx_bit_end_d) begin
            tx_cnt_q <= '0;
            tx_bit_q <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
`ifdef IO_PARITY_EN
              tx_q       <= tx_par_q;
              tx_state_q <= T_PAR;
`else
              tx_q       <= 1'b1;
              tx_state_q <= T_STOP;
`endif
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        T_PAR: begin
          if (tx_bit_end_d) begin
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            tx_state_q <= T_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        T_STOP: begin
          if (tx_bit_end_d) begin
            tx_cnt_q   <= '0;
            fgo_q      <= 1'b1;
            tx_state_q <= T_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic        rx_prev_q;
  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  inpr_q;
  logic        fgi_q;
  logic        ovr_q;
  logic        ferr_q;
`ifdef IO_PARITY_EN
  logic        rx_par_bad_q;
`endif
  logic        rx_frame_ok_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus_io.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

`ifdef IO_PARITY_EN
  assign rx_frame_ok_d = rx_sync_q && !rx_par_bad_q;
`else
  assign rx_frame_ok_d = rx_sync_q;
`endif

  // Strobe clears come first so that a commit or error set later in the same cycle wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      inpr_q       <= '0;
      fgi_q        <= 1'b0;
      ovr_q        <= 1'b0;
      ferr_q       <= 1'b0;
`ifdef IO_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      if (bus_io.inpr_read) fgi_q <= 1'b0;
      if (bus_io.err_clr) begin
        ovr_q  <= 1'b0;
        ferr_q <= 1'b0;
      end
      case (rx_state_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_q   <= 16'd1;
            rx_state_q <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt_q == HALF) begin
            rx_cnt_q   <= 16'd1;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_DATA: begin
          if (rx_cnt_q == CPB) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= 16'd1;
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
`ifdef IO_PARITY_EN
              rx_state_q <= R_PAR;
`else
              rx_state_q <= R_STOP;
`endif
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_PAR: begin
          if (rx_cnt_q == CPB) begin
`ifdef IO_PARITY_EN
            rx_par_bad_q <= rx_sync_q ^ (^rx_shift_q);
`endif
            rx_cnt_q   <= 16'd1;
            rx_state_q <= R_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_STOP: begin
          if (rx_cnt_q == CPB) begin
            rx_cnt_q   <= '0;
            rx_state_q <= R_IDLE;
            if (!rx_frame_ok_d) begin
              ferr_q <= 1'b1;
            end else if (!fgi_q || bus_io.inpr_read) begin
              inpr_q <= rx_shift_q;
              fgi_q  <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  assign bus_io.tx         = tx_q;
  assign bus_io.FGO        = fgo_q;
  assign bus_io.FGI        = fgi_q;
  assign bus_io.inpr_out   = inpr_q;
  assign bus_io.irq        = fgi_q | fgo_q;
  assign bus_io.rx_overrun = ovr_q;
  assign bus_io.frame_err  = ferr_q;

endmodule

// File: tb/tb_mano_io_port.sv
// Scoreboard bench for mano_io_port: tx bytes decoded off the pin, rx commits observed on INPR/FGI.
module tb_mano_io_port;
  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mano_io_port_if io ();

  mano_io_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (io)
  );

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  int unsigned commit_cyc = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  mon_b;
  logic        mon_s;
  logic        fgi_p  = 1'b0;
  logic [7:0]  inpr_p = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned t0);
    io.rx = 1'b0;
    t0 = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      io.rx = b[i];
      tick(CPB);
    end
    io.rx = stop_bit;
    tick(CPB);
    io.rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic pulse_err_clr();
    io.err_clr = 1'b1;
    tick(1);
    io.err_clr = 1'b0;
  endtask

  // Decode each tx frame at mid-bit and compare against the queued byte.
  initial begin : tx_mon
    forever begin
      tick(1);
      if (mon_en && io.tx === 1'b0) begin
        tick(CPB / 2);
        chk("tx_start_bit", io.tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          mon_b[i] = io.tx;
        end
        tick(CPB);
        mon_s = io.tx;
        if (tx_exp.size() == 0) chk("tx_unexpected", mon_b, 32'hFFFF_FFFF);
        else chk("tx_byte", mon_b, tx_exp.pop_front());
        chk("tx_stop_bit", mon_s, 1'b1);
      end
    end
  end

  // A commit shows as FGI rising or INPR changing.
  initial begin : rx_mon
    forever begin
      tick(1);
      if (mon_en && ((io.FGI && !fgi_p) || (io.inpr_out !== inpr_p))) begin
        commit_cyc = cyc;
        if (rx_exp.size() == 0) chk("rx_unexpected", io.inpr_out, 32'hFFFF_FFFF);
        else chk("rx_byte", io.inpr_out, rx_exp.pop_front());
      end
      fgi_p  = io.FGI;
      inpr_p = io.inpr_out;
    end
  end

  initial begin : main
    int unsigned t0, t1, lat, lat_use, base, n;
    io.outr_load = 1'b0;
    io.outr_in   = 8'h00;
    io.inpr_read = 1'b0;
    io.err_clr   = 1'b0;
    io.rx        = 1'b1;
    base = CPB / 2 + 9 * CPB + 2;

    tick(3);
    chk("rst_tx", io.tx, 1'b1);
    chk("rst_fgo", io.FGO, 1'b1);
    chk("rst_fgi", io.FGI, 1'b0);
    chk("rst_inpr", io.inpr_out, 8'h00);
    chk("rst_ovr", io.rx_overrun, 1'b0);
    chk("rst_ferr", io.frame_err, 1'b0);
    chk("rst_irq", io.irq, 1'b1);
    rst_n = 1'b1;
    tick(2);

    // Abort a frame with reset at cycle 50.
    io.outr_in = 8'h41;
    io.outr_load = 1'b1;
    tick(1);
    io.outr_load = 1'b0;
    tick(49);
    chk("mid_fgo", io.FGO, 1'b0);
    chk("mid_tx", io.tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", io.tx, 1'b1);
    chk("arst_fgo", io.FGO, 1'b1);
    chk("arst_fgi", io.FGI, 1'b0);
    chk("arst_inpr", io.inpr_out, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;

    // Normal transmit of 0x41 with a second load at cycle 20.
    tx_exp.push_back(8'h41);
    io.outr_in = 8'h41;
    io.outr_load = 1'b1;
    tick(1);
    io.outr_load = 1'b0;
    chk("fgo_drop", io.FGO, 1'b0);
    n = 0;
    while (io.FGO !== 1'b1 && n < 400) begin
      tick(1);
      n++;
      if (n == 1) chk("tx_fall", io.tx, 1'b0);
      io.outr_load = (n == 19);
      if (n == 19) io.outr_in = 8'hFF;
    end
    io.outr_load = 1'b0;
    chk("fgo_latency", n, 32'd161);
    tick(3 * CPB);
    chk("fgo_idle", io.FGO, 1'b1);
    chk("tx_idle", io.tx, 1'b1);

    // Receive 0x5A.
    rx_exp.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, t0);
    lat = commit_cyc - t0;
    chk("rx_fgi", io.FGI, 1'b1);
    chk("rx_irq", io.irq, 1'b1);
    chk("rx_inpr", io.inpr_out, 8'h5A);
    chk("rx_latency", (lat + 1 >= base) && (lat <= base + 3), 1'b1);

    // Overrun: 0x33 while FGI=1.
    send_frame(8'h33, 1'b1, t1);
    chk("ovr_set", io.rx_overrun, 1'b1);
    chk("ovr_inpr", io.inpr_out, 8'h5A);
    chk("ovr_fgi", io.FGI, 1'b1);
    io.inpr_read = 1'b1;
    tick(1);
    io.inpr_read = 1'b0;
    chk("read_fgi", io.FGI, 1'b0);
    chk("ovr_sticky", io.rx_overrun, 1'b1);
    pulse_err_clr();
    chk("ovr_clr", io.rx_overrun, 1'b0);

    // Bad stop bit.
    send_frame(8'hE7, 1'b0, t1);
    chk("ferr_set", io.frame_err, 1'b1);
    chk("ferr_fgi", io.FGI, 1'b0);
    chk("ferr_inpr", io.inpr_out, 8'h5A);
    pulse_err_clr();
    chk("ferr_clr", io.frame_err, 1'b0);

    // 4-cycle low glitch is a false start.
    io.rx = 1'b0;
    tick(4);
    io.rx = 1'b1;
    tick(3 * CPB);
    chk("glitch_fgi", io.FGI, 1'b0);
    chk("glitch_ferr", io.frame_err, 1'b0);
    chk("glitch_ovr", io.rx_overrun, 1'b0);

    // TX 0xA5 running while RX 0x96 arrives.
    tx_exp.push_back(8'hA5);
    io.outr_in = 8'hA5;
    io.outr_load = 1'b1;
    tick(1);
    io.outr_load = 1'b0;
    rx_exp.push_back(8'h96);
    send_frame(8'h96, 1'b1, t1);
    chk("dual_fgi", io.FGI, 1'b1);
    chk("dual_inpr", io.inpr_out, 8'h96);

    // inpr_read lands on the commit edge of 0xC3.
    lat_use = ((lat + 1 >= base) && (lat <= base + 3)) ? lat : base + 1;
    rx_exp.push_back(8'hC3);
    fork
      send_frame(8'hC3, 1'b1, t1);
      begin
        tick(int'(lat_use) - 1);
        io.inpr_read = 1'b1;
        tick(1);
        io.inpr_read = 1'b0;
      end
    join
    chk("same_inpr", io.inpr_out, 8'hC3);
    chk("same_fgi", io.FGI, 1'b1);
    chk("same_ovr", io.rx_overrun, 1'b0);

    n = 0;
    while (io.FGO !== 1'b1 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("final_fgo", io.FGO, 1'b1);
    tick(2 * CPB);
    chk("tx_sb_empty", tx_exp.size(), 32'd0);
    chk("rx_sb_empty", rx_exp.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
